counter_sat: RTL and testbench

Parametrised up/down counter, the successor to the fixed 4-bit counter. Width, step width, ceiling and overflow mode (wrap or saturate) are configurable. It adds sticky overflow and underflow flags and zero/max status. It sits wherever the design tracks credits, occupancy or outstanding transactions, and keeps the existing `value`/`value_next` contract so current instantiations can migrate directly.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_step_calc.sv | 50 +++++
 rtl/counter_sat.sv | 90 +++++++++
 tb/tb_counter_sat.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and parameter-legality rules for the counter family.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } counter_mode_e;

    // True when a (width, step width, ceiling) triple is a usable configuration.
    function automatic bit params_legal(
        input int unsigned     width,
        input int unsigned     step_w,
        input longint unsigned max_value
    );
        longint unsigned one;
        longint unsigned cap;
        longint unsigned step_max;
        one      = 64'd1;
        cap      = one << width;
        step_max = (one << step_w) - one;
        return (width >= 2) && (width <= 62) && (step_w >= 1) &&
               (max_value >= one) && (max_value < cap) &&
               (step_max <= max_value);
    endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count calculation with wrap/saturate correction.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int unsigned   WIDTH     = 4,
    parameter int unsigned   STEP_W    = 2,
    parameter counter_mode_e MODE      = CNT_WRAP,
    parameter int unsigned   MAX_VALUE = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0]  base,
    input  logic              incr_valid,
    input  logic [STEP_W-1:0] incr,
    input  logic              decr_valid,
    input  logic [STEP_W-1:0] decr,
    output logic [WIDTH-1:0]  value_next,
    output logic              ovf_evt,
    output logic              unf_evt
);

    // Two guard bits hold base + step without loss and carry the sign of base - step.
    localparam int unsigned RAW_W = WIDTH + 2;
    localparam logic signed [RAW_W-1:0] MAX_S = RAW_W'(MAX_VALUE);
    localparam logic signed [RAW_W-1:0] MOD_S = RAW_W'(MAX_VALUE + 1);

    logic signed [RAW_W-1:0] base_s;
    logic signed [RAW_W-1:0] incr_s;
    logic signed [RAW_W-1:0] decr_s;
    logic signed [RAW_W-1:0] raw;
    logic signed [RAW_W-1:0] corr;

    // Net raw result, range check and single-step correction.
    always_comb begin
        base_s  = RAW_W'(base);
        incr_s  = incr_valid ? RAW_W'(incr) : '0;
        decr_s  = decr_valid ? RAW_W'(decr) : '0;
        raw     = base_s + incr_s - decr_s;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        corr    = raw;
        if (raw[RAW_W-1]) begin
            unf_evt = 1'b1;
            corr    = (MODE == CNT_SAT) ? '0 : raw + MOD_S;
        end else if (raw > MAX_S) begin
            ovf_evt = 1'b1;
            corr    = (MODE == CNT_SAT) ? MAX_S : raw - MOD_S;
        end
        value_next = WIDTH'(corr);
    end

endmodule

// File: rtl/counter_sat.sv
// Parametrised up/down counter with wrap or saturate overflow handling,
// sticky overflow/underflow flags and registered zero/max status.
module counter_sat
    import counter_pkg::*;
#(
    parameter int unsigned   WIDTH     = 4,
    parameter int unsigned   STEP_W    = 2,
    parameter counter_mode_e MODE      = CNT_WRAP,
    parameter int unsigned   MAX_VALUE = 2**WIDTH - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit,
    input  logic [WIDTH-1:0]  initial_value,
    input  logic              incr_valid,
    input  logic [STEP_W-1:0] incr,
    input  logic              decr_valid,
    input  logic [STEP_W-1:0] decr,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  value,
    output logic [WIDTH-1:0]  value_next,
    output logic              overflow,
    output logic              underflow,
    output logic              is_zero,
    output logic              is_max
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

    // Reject configurations the single-correction arithmetic cannot handle.
    if (!params_legal(WIDTH, STEP_W, 64'(MAX_VALUE))) begin : g_bad_params
        $error("counter_sat: illegal WIDTH/STEP_W/MAX_VALUE combination");
    end

    logic [WIDTH-1:0] init_clamped;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] value_d;
    logic             ovf_evt;
    logic             unf_evt;

    // Clamp the reload value and pick the base the steps apply to.
    always_comb begin
        init_clamped = (initial_value > MAX_W) ? MAX_W : initial_value;
        base         = reinit ? init_clamped : value;
        value_d      = rst ? init_clamped : value_next;
    end

    counter_step_calc #(
        .WIDTH     (WIDTH),
        .STEP_W    (STEP_W),
        .MODE      (MODE),
        .MAX_VALUE (MAX_VALUE)
    ) u_step_calc (
        .base       (base),
        .incr_valid (incr_valid),
        .incr       (incr),
        .decr_valid (decr_valid),
        .decr       (decr),
        .value_next (value_next),
        .ovf_evt    (ovf_evt),
        .unf_evt    (unf_evt)
    );

    // Count register with status decoded from the value being loaded.
    always_ff @(posedge clk) begin
        value   <= value_d;
        is_zero <= (value_d == '0);
        is_max  <= (value_d == MAX_W);
    end

    // Sticky flags: an event sets and beats clear_flags/reinit, which clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clear_flags || reinit) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (clear_flags || reinit) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_sat.sv
// Scoreboard bench for counter_sat: three configurations share one input stream.
module tb_counter_sat;
    import counter_pkg::*;

    typedef struct {
        bit rst;
        bit reinit;
        bit iv;
        bit dv;
        bit clr;
        int init;
        int inc;
        int dec;
    } stim_t;

    typedef struct {
        int val;
        bit ovf;
        bit unf;
    } mstate_t;

    typedef struct {
        int val;
        bit ovf;
        bit unf;
        bit zero;
        bit max;
    } exp_t;

    // Per-instance configuration: ceiling and saturate mode.
    int    cfg_max [3] = '{15, 15, 9};
    bit    cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
    string dut_name[3] = '{"wrap15", "sat15", "wrap9"};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic [3:0] initial_value = 4'd0;
    logic       incr_valid = 1'b0;
    logic [1:0] incr = 2'd0;
    logic       decr_valid = 1'b0;
    logic [1:0] decr = 2'd0;
    logic       clear_flags = 1'b0;

    logic [3:0] val_o [3];
    logic [3:0] vn_o  [3];
    logic       ovf_o [3];
    logic       unf_o [3];
    logic       zero_o[3];
    logic       max_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t    q_st[3][$];
    int      q_vn[3][$];
    mstate_t mdl[3];
    exp_t    pending[3];
    bit      known = 1'b0;
    bit      have_pending = 1'b0;

    always #5 clk = ~clk;

    counter_sat #(.WIDTH(4), .STEP_W(2), .MODE(CNT_WRAP), .MAX_VALUE(15)) u_wrap15 (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
        .clear_flags(clear_flags), .value(val_o[0]), .value_next(vn_o[0]),
        .overflow(ovf_o[0]), .underflow(unf_o[0]), .is_zero(zero_o[0]), .is_max(max_o[0])
    );

    counter_sat #(.WIDTH(4), .STEP_W(2), .MODE(CNT_SAT), .MAX_VALUE(15)) u_sat15 (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
        .clear_flags(clear_flags), .value(val_o[1]), .value_next(vn_o[1]),
        .overflow(ovf_o[1]), .underflow(unf_o[1]), .is_zero(zero_o[1]), .is_max(max_o[1])
    );

    counter_sat #(.WIDTH(4), .STEP_W(2), .MODE(CNT_WRAP), .MAX_VALUE(9)) u_wrap9 (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
        .clear_flags(clear_flags), .value(val_o[2]), .value_next(vn_o[2]),
        .overflow(ovf_o[2]), .underflow(unf_o[2]), .is_zero(zero_o[2]), .is_max(max_o[2])
    );

    // Reference model: plain integer arithmetic on the counting rules.
    function automatic int clampv(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int raw_of(stim_t s, mstate_t m, int mx);
        int b;
        b = s.reinit ? clampv(s.init, mx) : m.val;
        return b + (s.iv ? s.inc : 0) - (s.dv ? s.dec : 0);
    endfunction

    function automatic int fix_raw(int raw, int mx, bit sat);
        if (raw > mx) return sat ? mx : raw - (mx + 1);
        if (raw < 0)  return sat ? 0 : raw + (mx + 1);
        return raw;
    endfunction

    function automatic mstate_t next_state(mstate_t m, stim_t s, int mx, bit sat);
        mstate_t n;
        int      raw;
        if (s.rst) begin
            n.val = clampv(s.init, mx);
            n.ovf = 1'b0;
            n.unf = 1'b0;
            return n;
        end
        raw   = raw_of(s, m, mx);
        n.val = fix_raw(raw, mx, sat);
        n.ovf = (raw > mx) ? 1'b1 : ((s.clr || s.reinit) ? 1'b0 : m.ovf);
        n.unf = (raw < 0)  ? 1'b1 : ((s.clr || s.reinit) ? 1'b0 : m.unf);
        return n;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, int exp_v);
        n_checks++;
        if (act !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s.%s at %0t: got %0d, expected %0d",
                     dut_name[d], name, $time, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected responses.
    task automatic drive(stim_t s);
        @(posedge clk);
        #1;
        if (have_pending) begin
            for (int d = 0; d < 3; d++) q_st[d].push_back(pending[d]);
        end
        rst           = s.rst;
        reinit        = s.reinit;
        initial_value = 4'(s.init);
        incr_valid    = s.iv;
        incr          = 2'(s.inc);
        decr_valid    = s.dv;
        decr          = 2'(s.dec);
        clear_flags   = s.clr;
        for (int d = 0; d < 3; d++) begin
            if (!s.rst && known)
                q_vn[d].push_back(fix_raw(raw_of(s, mdl[d], cfg_max[d]), cfg_max[d], cfg_sat[d]));
            mdl[d]          = next_state(mdl[d], s, cfg_max[d], cfg_sat[d]);
            pending[d].val  = mdl[d].val;
            pending[d].ovf  = mdl[d].ovf;
            pending[d].unf  = mdl[d].unf;
            pending[d].zero = (mdl[d].val == 0);
            pending[d].max  = (mdl[d].val == cfg_max[d]);
        end
        if (s.rst) known = 1'b1;
        have_pending = 1'b1;
    endtask

    function automatic stim_t mk(bit r, bit ri, int init, bit iv, int inc, bit dv, int dec, bit clr);
        stim_t s;
        s.rst = r; s.reinit = ri; s.init = init;
        s.iv = iv; s.inc = inc; s.dv = dv; s.dec = dec; s.clr = clr;
        return s;
    endfunction

    // Monitor: compare DUT outputs against the queued expectations.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (q_vn[d].size() > 0) begin
                int e;
                e = q_vn[d].pop_front();
                chk("value_next", d, 32'(vn_o[d]), e);
            end
            if (q_st[d].size() > 0) begin
                exp_t e;
                e = q_st[d].pop_front();
                chk("value",     d, 32'(val_o[d]),  e.val);
                chk("overflow",  d, 32'(ovf_o[d]),  int'(e.ovf));
                chk("underflow", d, 32'(unf_o[d]),  int'(e.unf));
                chk("is_zero",   d, 32'(zero_o[d]), int'(e.zero));
                chk("is_max",    d, 32'(max_o[d]),  int'(e.max));
            end
        end
    end

    initial begin
        stim_t s;
        int    left;
        // Reset to 5, then two +3 steps.
        drive(mk(1, 0, 5, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 5, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 5, 1, 3, 0, 0, 0));
        drive(mk(0, 0, 5, 1, 3, 0, 0, 0));
        // Ceiling crossing, sticky hold, then clear.
        drive(mk(0, 1, 14, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 1, 3, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1));
        // Floor crossing, then netted steps at zero.
        drive(mk(0, 1, 1, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 1, 2, 0));
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 1, 2, 1, 2, 0));
        drive(mk(0, 1, 2, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 1, 3, 0));
        // Netted steps at the ceiling produce no event.
        drive(mk(0, 1, 15, 1, 3, 1, 3, 0));
        // Reinit clamping and reinit combined with steps.
        drive(mk(0, 1, 12, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 1, 3, 0, 0, 0));
        drive(mk(0, 1, 4, 1, 2, 0, 0, 0));
        drive(mk(0, 1, 9, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 1, 3, 0, 0, 1));
        drive(mk(0, 1, 0, 0, 0, 1, 1, 0));
        // Reset while stepping, then count on from the reset value.
        drive(mk(1, 0, 7, 1, 3, 0, 0, 0));
        drive(mk(0, 0, 7, 1, 1, 0, 0, 0));
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            s.rst    = ($urandom_range(0, 39) == 0);
            s.reinit = ($urandom_range(0, 7) == 0);
            s.clr    = ($urandom_range(0, 7) == 0);
            s.init   = int'($urandom_range(0, 15));
            s.iv     = 1'($urandom_range(0, 1));
            s.inc    = int'($urandom_range(0, 3));
            s.dv     = 1'($urandom_range(0, 1));
            s.dec    = int'($urandom_range(0, 3));
            drive(s);
        end
        // Flush the last queued state.
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) q_st[d].push_back(pending[d]);
        rst = 1'b0; reinit = 1'b0; incr_valid = 1'b0; decr_valid = 1'b0; clear_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        left = 0;
        for (int d = 0; d < 3; d++) left += q_st[d].size() + q_vn[d].size();
        chk("drain", 0, 32'(left), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
